// File: rtl/board_io_pkg.sv
// board_io_pkg: constants and types shared by the EP4CE6 board I/O blocks.
//   KEY_ACTIVE_LEVEL : raw pin level of a pressed key (the keys pull low)
//   MS_DIV()         : number of clock cycles in one millisecond
//   key_evt_t        : per-channel debounced state and event pulses
package board_io_pkg;

    localparam logic KEY_ACTIVE_LEVEL = 1'b0;

    function automatic int MS_DIV(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    typedef struct packed {
        logic lvl;    // debounced level, 1 = pressed
        logic press;  // press accepted this cycle
        logic rel;    // release accepted this cycle
        logic lng;    // long-press threshold reached this cycle
    } key_evt_t;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel.
//   Two-flop synchroniser, tick-based debounce counter, long-press hold
//   counter and registered one-cycle event pulses.
// Ports:
//   clk50m, rst_n : clock, async active-low reset
//   tick          : shared 1 ms strobe, one cycle wide
//   sw            : raw key pin, active-low, asynchronous
//   evt           : registered level and press/release/long pulses
import board_io_pkg::*;

module key_debounce_ch #(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic     clk50m,
    input  logic     rst_n,
    input  logic     tick,
    input  logic     sw,
    output key_evt_t evt
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(LONG_MS + 1);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_MS - 1);
    localparam logic [HW-1:0] H_SAT  = HW'(LONG_MS);

    logic [1:0]    sync;
    logic          s;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          lvl, press, rel, lng;

    // Synchroniser idles at the released pin level so reset looks like
    // "no key pressed" to the filter.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) sync <= {2{~KEY_ACTIVE_LEVEL}};
        else        sync <= {sync[0], sw};
    end

    assign s = (sync[1] == KEY_ACTIVE_LEVEL);

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            dcnt  <= '0;
            hcnt  <= '0;
            lvl   <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            lng   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            lng   <= 1'b0;

            // Hold counter: saturates so the long pulse fires once per press.
            if (!lvl) begin
                hcnt <= '0;
            end else if (tick && hcnt != H_SAT) begin
                hcnt <= hcnt + 1'b1;
                lng  <= (hcnt == H_LAST);
            end

            // Debounce: any sample agreeing with the current level restarts
            // the count, so only an uninterrupted run of ticks is accepted.
            if (s == lvl) begin
                dcnt <= '0;
            end else if (tick) begin
                if (dcnt == D_LAST) begin
                    lvl   <= s;
                    dcnt  <= '0;
                    press <= s;
                    rel   <= ~s;
                    // Release wins over a coincident hold step: hold state
                    // is dropped together with the level.
                    if (!s) begin
                        hcnt <= '0;
                        lng  <= 1'b0;
                    end
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
    end

    assign evt = '{lvl: lvl, press: press, rel: rel, lng: lng};

endmodule

// File: rtl/key_debounce.sv
// key_debounce: debounced key front end for N active-low board keys.
//   Shared 1 ms tick divider feeding N independent key_debounce_ch channels.
// Ports:
//   clk50m      : system clock
//   rst_n       : async active-low reset
//   sw          : raw keys, active-low, asynchronous
//   key_level   : debounced state, 1 = pressed
//   key_press   : one-cycle pulse on accepted press
//   key_release : one-cycle pulse on accepted release
//   key_long    : one-cycle pulse once per press after LONG_MS ticks held
import board_io_pkg::*;

module key_debounce #(
    parameter int N           = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic         clk50m,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    output logic [N-1:0] key_level,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_long
);

    localparam int TICK_DIV = MS_DIV(CLK_HZ);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]        tcnt;
    logic                 tick;
    key_evt_t [N-1:0]     evt;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n)            tcnt <= '0;
        else if (tcnt == T_LAST) tcnt <= '0;
        else                   tcnt <= tcnt + 1'b1;
    end

    assign tick = (tcnt == T_LAST);

    for (genvar i = 0; i < N; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_ch (
            .clk50m (clk50m),
            .rst_n  (rst_n),
            .tick   (tick),
            .sw     (sw[i]),
            .evt    (evt[i])
        );

        assign key_level[i]   = evt[i].lvl;
        assign key_press[i]   = evt[i].press;
        assign key_release[i] = evt[i].rel;
        assign key_long[i]    = evt[i].lng;
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed test of key_debounce with a 10-cycle tick,
// 3-tick debounce and 8-tick long press.
module tb_key_debounce;

    logic       clk50m = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] sw     = 4'b0000;
    logic [3:0] key_level, key_press, key_release, key_long;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int viol   = 0;
    int press_cnt [4] = '{0, 0, 0, 0};
    int rel_cnt   [4] = '{0, 0, 0, 0};
    int long_cnt  [4] = '{0, 0, 0, 0};
    int press_cyc [4] = '{0, 0, 0, 0};
    int long_cyc  [4] = '{0, 0, 0, 0};

    key_debounce #(
        .N           (4),
        .CLK_HZ      (10_000),
        .DEBOUNCE_MS (3),
        .LONG_MS     (8)
    ) u_dut (
        .clk50m      (clk50m),
        .rst_n       (rst_n),
        .sw          (sw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk50m = ~clk50m;

    always @(posedge clk50m) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge.
    always @(negedge clk50m) begin
        for (int i = 0; i < 4; i++) begin
            if (key_press[i])   begin press_cnt[i] <= press_cnt[i] + 1; press_cyc[i] <= cyc; end
            if (key_release[i]) rel_cnt[i] <= rel_cnt[i] + 1;
            if (key_long[i])    begin long_cnt[i] <= long_cnt[i] + 1; long_cyc[i] <= cyc; end
        end
        if (|(key_press & key_release) || |(key_press & key_long)) viol <= viol + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs change 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk50m);
        #1;
    endtask

    function automatic int in_win(input int d);
        return (d >= 21 && d <= 32) ? 1 : 0;
    endfunction

    int r, s0, p0, p1, p2, p3, r0, l0, l2;

    initial begin
        // Reset with all keys held down.
        step(5);
        chk("rst_outputs", {key_level, key_press, key_release, key_long}, 0);
        rst_n = 1'b1;
        r = cyc;
        step(40);
        chk("rst_press_all", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 4);
        // Ticks land 10/20/30 cycles after reset release; third one accepts.
        chk("rst_press_lat", press_cyc[0] - r, 30);
        chk("rst_level", key_level, 4'b1111);

        sw = 4'b1111;
        step(40);
        chk("rel_all", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 4);
        chk("rel_level", key_level, 0);

        // Clean press/release on key 0.
        p0 = press_cnt[0]; r0 = rel_cnt[0]; l0 = long_cnt[0];
        sw[0] = 1'b0;
        s0 = cyc;
        step(45);
        chk("clean_level", key_level, 4'b0001);
        chk("clean_lat", in_win(press_cyc[0] - s0), 1);
        step(15);
        sw[0] = 1'b1;
        step(45);
        chk("clean_press", press_cnt[0] - p0, 1);
        chk("clean_rel", rel_cnt[0] - r0, 1);
        chk("clean_nolong", long_cnt[0] - l0, 0);
        chk("clean_level_off", key_level, 0);

        // Bounce on key 1: 7-cycle toggles never see three clean ticks.
        p1 = press_cnt[1];
        for (int i = 0; i < 14; i++) begin
            sw[1] = ~sw[1];
            step(7);
        end
        chk("bounce_quiet", press_cnt[1] - p1 + rel_cnt[1], rel_cnt[1]);
        chk("bounce_level", key_level[1], 0);
        sw[1] = 1'b0;
        s0 = cyc;
        step(40);
        chk("bounce_press", press_cnt[1] - p1, 1);
        chk("bounce_lat", in_win(press_cyc[1] - s0), 1);
        sw[1] = 1'b1;
        step(40);

        // Long press on key 2.
        p2 = press_cnt[2]; l2 = long_cnt[2];
        sw[2] = 1'b0;
        step(150);
        chk("long_press", press_cnt[2] - p2, 1);
        chk("long_once", long_cnt[2] - l2, 1);
        chk("long_delay", long_cyc[2] - press_cyc[2], 80);
        r0 = rel_cnt[2];
        sw[2] = 1'b1;
        step(40);
        chk("long_rel", rel_cnt[2] - r0, 1);
        chk("long_once_after", long_cnt[2] - l2, 1);

        // Simultaneous falls on keys 3 and 0.
        p0 = press_cnt[0]; p3 = press_cnt[3];
        sw[3] = 1'b0; sw[0] = 1'b0;
        step(40);
        chk("sim_press0", press_cnt[0] - p0, 1);
        chk("sim_press3", press_cnt[3] - p3, 1);
        chk("sim_same_cyc", press_cyc[3] - press_cyc[0], 0);
        sw[3] = 1'b1; sw[0] = 1'b1;
        step(40);

        // Reset five ticks into a long press of key 2, key kept held.
        p2 = press_cnt[2]; l2 = long_cnt[2];
        sw[2] = 1'b0;
        step(40);
        chk("mid_press", press_cnt[2] - p2, 1);
        if (press_cyc[2] + 50 > cyc) step(press_cyc[2] + 50 - cyc);
        rst_n = 1'b0;
        step(3);
        chk("mid_rst_level", key_level, 0);
        step(60);
        chk("mid_rst_nolong", long_cnt[2] - l2, 0);
        rst_n = 1'b1;
        r = cyc;
        step(40);
        chk("mid_repress", press_cnt[2] - p2, 2);
        chk("mid_repress_lat", press_cyc[2] - r, 30);
        step(90);
        chk("mid_long_once", long_cnt[2] - l2, 1);
        chk("mid_long_delay", long_cyc[2] - press_cyc[2], 80);
        sw[2] = 1'b1;
        step(40);

        chk("no_overlap", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
